// File: rtl/noc_pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkt_pkg
//  Description : Shared NoC spike-packet definitions. It holds the packet
//                width, the field offsets and widths, the coordinate width,
//                the drop-reason encoding and a helper that classifies a
//                packet at a receiving tile.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Packet layout:
//    [31:28] dst_x  [27:24] dst_y  [23:20] src_x  [19:16] src_y
//    [15:8]  axon_idx              [7:0]   reserved
// ============================================================================
package noc_pkt_pkg;

    localparam int PACKET_W  = 32;
    localparam int COORD_W   = 4;
    localparam int AXON_W    = 8;
    localparam int RSVD_W    = 8;

    localparam int DST_X_LSB = 28;
    localparam int DST_Y_LSB = 24;
    localparam int SRC_X_LSB = 20;
    localparam int SRC_Y_LSB = 16;
    localparam int AXON_LSB  = 8;
    localparam int RSVD_LSB  = 0;

    typedef enum logic [1:0] {
        DROP_NONE     = 2'd0,
        DROP_OVERFLOW = 2'd1,
        DROP_MISROUTE = 2'd2,
        DROP_BAD_AXON = 2'd3
    } drop_reason_e;

    // Destination mismatch takes priority over a bad axon index. Either one
    // causes a discard, so the order only affects the reported reason.
    function automatic drop_reason_e classify_pkt(
        input logic [COORD_W-1:0] dst_x,
        input logic [COORD_W-1:0] dst_y,
        input logic [AXON_W-1:0]  axon,
        input logic [COORD_W-1:0] local_x,
        input logic [COORD_W-1:0] local_y,
        input logic [31:0]        num_axons
    );
        if ((dst_x != local_x) || (dst_y != local_y)) begin
            return DROP_MISROUTE;
        end
        if ({{(32-AXON_W){1'b0}}, axon} >= num_axons) begin
            return DROP_BAD_AXON;
        end
        return DROP_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO. DEPTH must be a power of two, because the
//                pointers wrap naturally. A push is ignored while the FIFO is
//                full and a pop is ignored while it is empty. The full flag
//                comes from the registered count only, so a pop in the same
//                cycle does not make room for a push.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports:
//    clk, rst_n    clock, synchronous active-low reset
//    push, din     write request and data
//    pop, dout     read request; dout shows the head entry (first-word fall-through)
//    full, empty   occupancy flags
//    count         number of entries held (0..DEPTH)
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full      = (r_count == (c_PTR_W+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // The storage array has no reset. Entries are only read when count shows them valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spike_packet_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : spike_packet_receiver
//  Description : Neuron-side sink for the router local output port. Incoming
//                spike packets are buffered in a FIFO. Each packet is
//                checked against this tile's coordinates, and its axon index
//                is decoded into an accumulating spike vector. On every
//                step_tick the accumulated vector is copied into a
//                presentation bank for the neuron core, and the accumulator
//                clears.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports:
//    clk, rst_n       clock, synchronous active-low reset
//    pkt_in/pkt_valid packet from the router (one per high cycle)
//    rx_full          back-pressure to the router (FIFO full)
//    step_tick        timestep boundary pulse
//    spike_vec        presented vector for the step just closed
//    spike_vec_valid  spike_vec not yet consumed
//    spike_vec_ack    neuron consumed spike_vec
//    drop_cnt         saturating count of discarded packets
//    overrun          sticky: vector replaced before it was consumed
// ============================================================================
module spike_packet_receiver #(
    parameter int         PACKET_W   = 32,
    parameter int         FIFO_DEPTH = 4,
    parameter int         NUM_AXONS  = 64,
    parameter logic [3:0] LOCAL_X    = 4'd0,
    parameter logic [3:0] LOCAL_Y    = 4'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PACKET_W-1:0]  pkt_in,
    input  logic                 pkt_valid,
    output logic                 rx_full,
    input  logic                 step_tick,
    output logic [NUM_AXONS-1:0] spike_vec,
    output logic                 spike_vec_valid,
    input  logic                 spike_vec_ack,
    output logic [7:0]           drop_cnt,
    output logic                 overrun
);

    import noc_pkt_pkg::*;

    localparam int         c_CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int         c_AXON_IDX_W = $clog2(NUM_AXONS);
    localparam logic [0:0] S_IDLE       = 1'b0;
    localparam logic [0:0] S_DECODE     = 1'b1;

    logic [0:0]           r_state;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_overflow;
    logic                 w_decode_drop;
    logic                 w_nonempty_next;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_CNT_W-1:0]   w_fifo_count;
    logic [PACKET_W-1:0]  w_head;
    drop_reason_e         w_reason;
    logic [NUM_AXONS-1:0] w_set_vec;
    logic [NUM_AXONS-1:0] w_accum_next;
    logic [NUM_AXONS-1:0] r_accum;
    logic [NUM_AXONS-1:0] r_spike_vec;
    logic                 r_valid;
    logic                 r_overrun;
    logic [7:0]           r_drop_cnt;
    logic [1:0]           w_drop_inc;
    logic [8:0]           w_drop_sum;
    logic                 w_unused_fields;

    // ---------------------------------------------------------------- ingress
    assign w_push     = pkt_valid && !w_fifo_full;
    assign w_overflow = pkt_valid && w_fifo_full;

    sync_fifo #(
        .WIDTH (PACKET_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (pkt_in),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // ------------------------------------------------------------- drain FSM
    // The state is computed from the FIFO occupancy expected next cycle, so
    // DECODE exactly tracks "FIFO non-empty". The head is therefore popped in
    // the first cycle it is visible, with no extra cycle of latency.
    assign w_pop           = (r_state == S_DECODE) && !w_fifo_empty;
    assign w_nonempty_next = w_push || (w_fifo_count > {{(c_CNT_W-1){1'b0}}, w_pop});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nonempty_next ? S_DECODE : S_IDLE;
        end
    end

    // ----------------------------------------------------------------- decode
    assign w_reason = classify_pkt(w_head[DST_X_LSB +: COORD_W],
                                   w_head[DST_Y_LSB +: COORD_W],
                                   w_head[AXON_LSB +: AXON_W],
                                   LOCAL_X, LOCAL_Y, NUM_AXONS);
    assign w_decode_drop   = w_pop && (w_reason != DROP_NONE);
    assign w_unused_fields = ^{w_head[SRC_X_LSB +: 2*COORD_W], w_head[RSVD_LSB +: RSVD_W]};

    always_comb begin
        w_set_vec = '0;
        if (w_pop && (w_reason == DROP_NONE)) begin
            w_set_vec[w_head[AXON_LSB +: c_AXON_IDX_W]] = 1'b1;
        end
    end

    // A spike decoded in the tick cycle belongs to the step being closed.
    assign w_accum_next = r_accum | w_set_vec;

    // ------------------------------------------------- accumulate / present
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_accum     <= '0;
            r_spike_vec <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (step_tick) begin
                r_spike_vec <= w_accum_next;
                r_accum     <= '0;
                r_valid     <= 1'b1;
                if (r_valid && !spike_vec_ack) begin
                    r_overrun <= 1'b1;
                end
            end else begin
                r_accum <= w_accum_next;
                if (spike_vec_ack) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------ drop count
    assign w_drop_inc = {1'b0, w_overflow} + {1'b0, w_decode_drop};
    assign w_drop_sum = {1'b0, r_drop_cnt} + {7'b0, w_drop_inc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign rx_full         = w_fifo_full;
    assign spike_vec       = r_spike_vec;
    assign spike_vec_valid = r_valid;
    assign drop_cnt        = r_drop_cnt;
    assign overrun         = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spike_packet_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spike_packet_receiver
//  Description : Self-checking bench for spike_packet_receiver. It applies a
//                directed vector table, a few multi-cycle sequences, and a
//                randomized run checked against a transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spike_packet_receiver;

    localparam int DEPTH = 4;
    localparam int NAX   = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [31:0]    pkt_in = '0;
    logic           pkt_valid = 1'b0;
    logic           step_tick = 1'b0;
    logic           spike_vec_ack = 1'b0;
    logic           rx_full;
    logic [NAX-1:0] spike_vec;
    logic           spike_vec_valid;
    logic [7:0]     drop_cnt;
    logic           overrun;

    int checks   = 0;
    int failures = 0;

    spike_packet_receiver #(
        .PACKET_W   (32),
        .FIFO_DEPTH (DEPTH),
        .NUM_AXONS  (NAX),
        .LOCAL_X    (4'd0),
        .LOCAL_Y    (4'd0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pkt_in          (pkt_in),
        .pkt_valid       (pkt_valid),
        .rx_full         (rx_full),
        .step_tick       (step_tick),
        .spike_vec       (spike_vec),
        .spike_vec_valid (spike_vec_valid),
        .spike_vec_ack   (spike_vec_ack),
        .drop_cnt        (drop_cnt),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int dx, input int dy, input int ax);
        logic [31:0] p;
        p = {dx[3:0], dy[3:0], 4'h0, 4'h0, ax[7:0], 8'h00};
        return p;
    endfunction

    // Drive inputs for one cycle, clock once, then return 1ns after the edge.
    task automatic cyc(input logic pv, input logic [31:0] pkt, input logic tick, input logic ack);
        pkt_valid     = pv;
        pkt_in        = pkt;
        step_tick     = tick;
        spike_vec_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic           pv;
        logic [31:0]    pkt;
        logic           tick;
        logic           ack;
        logic           full;
        logic [NAX-1:0] vec;
        logic           valid;
        logic [7:0]     drop;
        logic           ovr;
    } vec_t;

    vec_t tbl[19];

    // Transaction-level reference model.
    logic [31:0]    mq[$];
    logic [NAX-1:0] m_acc, m_vec;
    logic           m_valid, m_ovr;
    int             m_drop;

    task automatic model_step(input logic pv, input logic [31:0] pkt, input logic tick, input logic ack);
        logic [31:0] h;
        bit          was_full;
        int          ax;
        was_full = (mq.size() == DEPTH);
        if (mq.size() > 0) begin
            h  = mq.pop_front();
            ax = int'(h[15:8]);
            if (h[31:28] == 4'd0 && h[27:24] == 4'd0 && ax < NAX) m_acc[ax] = 1'b1;
            else m_drop++;
        end
        if (pv) begin
            if (was_full) m_drop++;
            else mq.push_back(pkt);
        end
        if (m_drop > 255) m_drop = 255;
        if (tick) begin
            if (m_valid && !ack) m_ovr = 1'b1;
            m_vec   = m_acc;
            m_acc   = '0;
            m_valid = 1'b1;
        end else if (ack) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        logic [NAX-1:0] exp_vec;
        logic [NAX-1:0] b5, b3;
        int             waits;
        b5 = '0; b5[5] = 1'b1;
        b3 = '0; b3[3] = 1'b1;

        //                pv    pkt           tick  ack   full  vec  valid drop   ovr
        tbl[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, '0, 1'b0, 8'd0, 1'b0};
        tbl[1]  = '{1'b1, mk(0,0,5),     1'b0, 1'b0, 1'b0, '0, 1'b0, 8'd0, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, '0, 1'b0, 8'd0, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, '0, 1'b0, 8'd0, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, '0, 1'b0, 8'd0, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, b5, 1'b1, 8'd0, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, b5, 1'b0, 8'd0, 1'b0};
        tbl[7]  = '{1'b1, mk(1,0,2),     1'b0, 1'b0, 1'b0, b5, 1'b0, 8'd0, 1'b0};
        tbl[8]  = '{1'b1, mk(0,0,70),    1'b0, 1'b0, 1'b0, b5, 1'b0, 8'd1, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, b5, 1'b0, 8'd2, 1'b0};
        tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, '0, 1'b1, 8'd2, 1'b0};
        tbl[11] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, '0, 1'b0, 8'd2, 1'b0};
        tbl[12] = '{1'b1, mk(0,0,3),     1'b0, 1'b0, 1'b0, '0, 1'b0, 8'd2, 1'b0};
        tbl[13] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, b3, 1'b1, 8'd2, 1'b0};
        tbl[14] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, b3, 1'b0, 8'd2, 1'b0};
        tbl[15] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, '0, 1'b1, 8'd2, 1'b0};
        tbl[16] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, '0, 1'b1, 8'd2, 1'b0};
        tbl[17] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, '0, 1'b1, 8'd2, 1'b1};
        tbl[18] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, '0, 1'b0, 8'd2, 1'b1};

        // ---------------------------------------------------- reset state
        do_reset();
        check("reset.full",    {127'b0, rx_full}, 128'd0);
        check("reset.vec",     {64'b0, spike_vec}, 128'd0);
        check("reset.valid",   {127'b0, spike_vec_valid}, 128'd0);
        check("reset.drop",    {120'b0, drop_cnt}, 128'd0);
        check("reset.overrun", {127'b0, overrun}, 128'd0);

        // ----------------------------------------------------- vector table
        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].pv, tbl[i].pkt, tbl[i].tick, tbl[i].ack);
            check($sformatf("tbl[%0d].full", i),  {127'b0, rx_full},         {127'b0, tbl[i].full});
            check($sformatf("tbl[%0d].vec", i),   {64'b0, spike_vec},        {64'b0, tbl[i].vec});
            check($sformatf("tbl[%0d].valid", i), {127'b0, spike_vec_valid}, {127'b0, tbl[i].valid});
            check($sformatf("tbl[%0d].drop", i),  {120'b0, drop_cnt},        {120'b0, tbl[i].drop});
            check($sformatf("tbl[%0d].ovr", i),   {127'b0, overrun},         {127'b0, tbl[i].ovr});
        end

        // ------------------------- burst of 6 honouring back-pressure
        do_reset();
        exp_vec = '0;
        for (int i = 0; i < 6; i++) begin
            waits = 0;
            while (rx_full && waits < 20) begin
                cyc(1'b0, '0, 1'b0, 1'b0);
                waits++;
            end
            check($sformatf("burst.wait%0d", i), {127'b0, rx_full}, 128'd0);
            cyc(1'b1, mk(0, 0, 10 + i*7), 1'b0, 1'b0);
            exp_vec[10 + i*7] = 1'b1;
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("burst.vec",   {64'b0, spike_vec}, {64'b0, exp_vec});
        check("burst.valid", {127'b0, spike_vec_valid}, 128'd1);
        check("burst.drop",  {120'b0, drop_cnt}, 128'd0);

        // ---------------------------------------- reset mid-operation
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, mk(1, 1, 4), 1'b0, 1'b0);
        cyc(1'b1, mk(0, 0, 1), 1'b0, 1'b0);
        cyc(1'b1, mk(0, 0, 2), 1'b0, 1'b0);
        cyc(1'b1, mk(0, 0, 3), 1'b0, 1'b0);
        check("pre_rst.overrun", {127'b0, overrun}, 128'd1);
        check("pre_rst.drop",    {120'b0, drop_cnt}, 128'd1);
        rst_n = 1'b0;
        cyc(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        check("mid_rst.state", {rx_full, spike_vec_valid, overrun, drop_cnt, spike_vec}, 128'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("mid_rst.vec",   {64'b0, spike_vec}, 128'd0);
        check("mid_rst.valid", {127'b0, spike_vec_valid}, 128'd1);
        check("mid_rst.cnt",   {119'b0, rx_full, drop_cnt}, 128'd0);

        // ----------------------------------------- drop counter saturation
        do_reset();
        for (int i = 0; i < 254; i++) cyc(1'b1, mk(2, 3, 1), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("sat.254", {120'b0, drop_cnt}, 128'd254);
        for (int i = 0; i < 10; i++) cyc(1'b1, mk(0, 0, 200), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("sat.ff", {120'b0, drop_cnt}, 128'hFF);

        // --------------------------------------------- randomized vs model
        do_reset();
        mq.delete();
        m_acc = '0; m_vec = '0; m_valid = 1'b0; m_ovr = 1'b0; m_drop = 0;
        for (int n = 0; n < 1500; n++) begin
            logic        pv, tk, ak;
            logic [31:0] p;
            int          dx, dy;
            pv = ($urandom_range(0, 1) == 1);
            dx = 0; dy = 0;
            if ($urandom_range(0, 9) == 0) begin
                dx = int'($urandom_range(0, 15));
                dy = int'($urandom_range(1, 15));
            end
            p = mk(dx, dy, int'($urandom_range(0, 70)));
            p[23:16] = 8'($urandom);
            p[7:0]   = 8'($urandom);
            tk = ($urandom_range(0, 15) == 0);
            ak = ($urandom_range(0, 3) == 0);
            model_step(pv, p, tk, ak);
            cyc(pv, p, tk, ak);
            check($sformatf("rand[%0d]", n),
                  {53'b0, rx_full, spike_vec_valid, overrun, drop_cnt, spike_vec},
                  {53'b0, (mq.size() == DEPTH), m_valid, m_ovr, 8'(m_drop), m_vec});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
